// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the MIPS-style ALU-control decoder: widths, ALU select
// encodings, ALUop codes and R-type function codes.
package alu_ctrl_pkg;

    localparam int FUNC_WIDTH  = 6;
    localparam int ALUOP_WIDTH = 2;
    localparam int CTRL_WIDTH  = 4;

    typedef enum logic [CTRL_WIDTH-1:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_ctrl_e;

    localparam logic [ALUOP_WIDTH-1:0] mem_aluop     = 2'b00;
    localparam logic [ALUOP_WIDTH-1:0] branch_aluop  = 2'b01;
    localparam logic [ALUOP_WIDTH-1:0] arith_aluop   = 2'b10;
    localparam logic [ALUOP_WIDTH-1:0] illegal_aluop = 2'b11;

    localparam logic [FUNC_WIDTH-1:0] add_func  = 6'b100000;
    localparam logic [FUNC_WIDTH-1:0] addu_func = 6'b100001;
    localparam logic [FUNC_WIDTH-1:0] sub_func  = 6'b100010;
    localparam logic [FUNC_WIDTH-1:0] subu_func = 6'b100011;
    localparam logic [FUNC_WIDTH-1:0] and_func  = 6'b100100;
    localparam logic [FUNC_WIDTH-1:0] or_func   = 6'b100101;
    localparam logic [FUNC_WIDTH-1:0] nor_func  = 6'b100111;
    localparam logic [FUNC_WIDTH-1:0] slt_func  = 6'b101010;
    localparam logic [FUNC_WIDTH-1:0] jr_func   = 6'b001000;

endpackage

// File: rtl/alu_func_decode.sv
// Combinational R-type function decoder: func -> {ALU select, illegal flag}.
// Define ALU_CTRL_EXT_FUNC_EN to also accept addu/subu/nor.
module alu_func_decode
    import alu_ctrl_pkg::*;
(
    input  logic [FUNC_WIDTH-1:0] func,
    output logic [CTRL_WIDTH-1:0] ctrl,
    output logic                  illegal
);

    always_comb begin
        ctrl    = ALU_AND;
        illegal = 1'b0;
        case (func)
            add_func: ctrl = ALU_ADD;
            sub_func: ctrl = ALU_SUB;
            and_func: ctrl = ALU_AND;
            or_func:  ctrl = ALU_OR;
            slt_func: ctrl = ALU_SLT;
            // jr does not use the ALU result; ADD keeps the datapath benign
            jr_func:  ctrl = ALU_ADD;
`ifdef ALU_CTRL_EXT_FUNC_EN
            addu_func: ctrl = ALU_ADD;
            subu_func: ctrl = ALU_SUB;
            nor_func:  ctrl = ALU_NOR;
`endif
            default: begin
                ctrl    = ALU_AND;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_control_32.sv
// Registered ALU-control decoder: ALUop mux around the func decoder, with one
// cycle of latency. Optional macro: ALU_CTRL_EXT_FUNC_EN (addu/subu/nor).
module alu_control_32 #(
    parameter int FUNC_W  = 6,
    parameter int ALUOP_W = 2,
    parameter int CTRL_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FUNC_W-1:0]  func,
    input  logic [ALUOP_W-1:0] alu_op,
    output logic [CTRL_W-1:0]  alu_control,
    output logic               err_illegal_func_code,
    output logic               err_illegal_alu_op
);

    import alu_ctrl_pkg::*;

    logic [CTRL_W-1:0] func_ctrl;
    logic              func_illegal;
    logic [CTRL_W-1:0] ctrl_next;
    logic              err_func_next;
    logic              err_op_next;

    alu_func_decode u_func_decode (
        .func    (func),
        .ctrl    (func_ctrl),
        .illegal (func_illegal)
    );

    // The func decode only matters for R-type; the error flags are mutually exclusive by construction
    always_comb begin
        ctrl_next     = ALU_AND;
        err_func_next = 1'b0;
        err_op_next   = 1'b0;
        case (alu_op)
            mem_aluop:    ctrl_next = ALU_ADD;
            branch_aluop: ctrl_next = ALU_SUB;
            arith_aluop: begin
                ctrl_next     = func_ctrl;
                err_func_next = func_illegal;
            end
            default: begin
                ctrl_next   = ALU_AND;
                err_op_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_control           <= '0;
            err_illegal_func_code <= 1'b0;
            err_illegal_alu_op    <= 1'b0;
        end else begin
            alu_control           <= ctrl_next;
            err_illegal_func_code <= err_func_next;
            err_illegal_alu_op    <= err_op_next;
        end
    end

endmodule

// File: tb/tb_alu_control_32.sv
// Scoreboard bench for alu_control_32: directed vectors push expected results,
// a monitor pops and compares one edge later.
module tb_alu_control_32;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] func;
    logic [1:0] alu_op;
    logic [3:0] alu_control;
    logic       err_illegal_func_code;
    logic       err_illegal_alu_op;

    typedef struct {
        logic [3:0] ctrl;
        logic       ef;
        logic       ea;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    bit   has_last = 1'b0;
    int   checks = 0;
    int   errors = 0;

    alu_control_32 dut (
        .clk                   (clk),
        .rst                   (rst),
        .func                  (func),
        .alu_op                (alu_op),
        .alu_control           (alu_control),
        .err_illegal_func_code (err_illegal_func_code),
        .err_illegal_alu_op    (err_illegal_alu_op)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input exp_t e, input string tag);
        checks++;
        if (alu_control !== e.ctrl || err_illegal_func_code !== e.ef || err_illegal_alu_op !== e.ea) begin
            errors++;
            $display("[TB] FAIL %s%s: got ctrl=%b ef=%b ea=%b, expected ctrl=%b ef=%b ea=%b",
                     tag, e.name, alu_control, err_illegal_func_code, err_illegal_alu_op,
                     e.ctrl, e.ef, e.ea);
        end
    endtask

    // Drive on the falling edge; just after, the output must still show the previous result
    task automatic applyStimulus(input logic r, input logic [1:0] op, input logic [5:0] f,
                                 input logic [3:0] ec, input logic eef, input logic eea,
                                 input string nm);
        exp_t e;
        @(negedge clk);
        rst    = r;
        alu_op = op;
        func   = f;
        e.ctrl = ec;
        e.ef   = eef;
        e.ea   = eea;
        e.name = nm;
        sb.push_back(e);
        #1;
        if (has_last) checkOutput(last_exp, "hold/");
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checkOutput(e, "");
            last_exp = e;
            has_last = 1'b1;
        end
    end

    initial begin
        logic [5:0] any_funcs [5];
        logic [5:0] bad_funcs [5];
        any_funcs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        bad_funcs = '{6'b111010, 6'b111111, 6'b110110, 6'b110101, 6'b101011};

        rst    = 1'b1;
        alu_op = 2'b01;
        func   = 6'b100010;

        applyStimulus(1'b1, 2'b01, 6'b100010, 4'b0000, 1'b0, 1'b0, "reset0");
        applyStimulus(1'b1, 2'b01, 6'b100010, 4'b0000, 1'b0, 1'b0, "reset1");
        applyStimulus(1'b0, 2'b01, 6'b100010, 4'b0110, 1'b0, 1'b0, "release_sub");

        for (int i = 0; i < 5; i++)
            applyStimulus(1'b0, 2'b00, any_funcs[i], 4'b0010, 1'b0, 1'b0, "mem_add");
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b0, 2'b01, any_funcs[i], 4'b0110, 1'b0, 1'b0, "beq_sub");

        applyStimulus(1'b0, 2'b10, 6'b100000, 4'b0010, 1'b0, 1'b0, "rt_add");
        applyStimulus(1'b0, 2'b10, 6'b100010, 4'b0110, 1'b0, 1'b0, "rt_sub");
        applyStimulus(1'b0, 2'b10, 6'b100100, 4'b0000, 1'b0, 1'b0, "rt_and");
        applyStimulus(1'b0, 2'b10, 6'b100101, 4'b0001, 1'b0, 1'b0, "rt_or");
        applyStimulus(1'b0, 2'b10, 6'b101010, 4'b0111, 1'b0, 1'b0, "rt_slt");
        applyStimulus(1'b0, 2'b10, 6'b001000, 4'b0010, 1'b0, 1'b0, "rt_jr");

        for (int i = 0; i < 5; i++)
            applyStimulus(1'b0, 2'b10, bad_funcs[i], 4'b0000, 1'b1, 1'b0, "bad_func");

        applyStimulus(1'b0, 2'b11, 6'b100000, 4'b0000, 1'b0, 1'b1, "bad_op_add");
        applyStimulus(1'b0, 2'b11, 6'b111111, 4'b0000, 1'b0, 1'b1, "bad_op_ff");
        applyStimulus(1'b0, 2'b00, 6'b111111, 4'b0010, 1'b0, 1'b0, "op_clear");

`ifdef ALU_CTRL_EXT_FUNC_EN
        applyStimulus(1'b0, 2'b10, 6'b100111, 4'b1100, 1'b0, 1'b0, "ext_nor");
        applyStimulus(1'b0, 2'b10, 6'b100001, 4'b0010, 1'b0, 1'b0, "ext_addu");
        applyStimulus(1'b0, 2'b10, 6'b100011, 4'b0110, 1'b0, 1'b0, "ext_subu");
`else
        applyStimulus(1'b0, 2'b10, 6'b100111, 4'b0000, 1'b1, 1'b0, "noext_nor");
        applyStimulus(1'b0, 2'b10, 6'b100001, 4'b0000, 1'b1, 1'b0, "noext_addu");
        applyStimulus(1'b0, 2'b10, 6'b100011, 4'b0000, 1'b1, 1'b0, "noext_subu");
`endif

        applyStimulus(1'b0, 2'b10, 6'b101010, 4'b0111, 1'b0, 1'b0, "pre_reset_slt");
        applyStimulus(1'b1, 2'b10, 6'b101010, 4'b0000, 1'b0, 1'b0, "mid_reset");
        applyStimulus(1'b1, 2'b11, 6'b111111, 4'b0000, 1'b0, 1'b0, "reset_over_bad_op");
        applyStimulus(1'b0, 2'b11, 6'b111111, 4'b0000, 1'b0, 1'b1, "post_reset_bad_op");

        for (int n = 0; n < 10 && sb.size() > 0; n++)
            @(posedge clk);
        #2;
        if (sb.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d expected results left in scoreboard, required 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
